// File: rtl/freq_stepper_if.sv
// Request/response bundle between the front-panel logic and the frequency stepper.
// The master drives step/load requests; the slave returns the frequency state and strobes.
interface freq_stepper_if #(
    parameter int unsigned FTW_W      = 32,
    parameter int unsigned BIN_W      = 18,
    parameter int unsigned BCD_DIGITS = 6
);
    logic                    trig_up;
    logic                    trig_down;
    logic [1:0]              mode;
    logic                    load;
    logic [BIN_W-1:0]        load_khz;
    logic [FTW_W-1:0]        load_ftw;
    logic [FTW_W-1:0]        freq_ftw;
    logic [BIN_W-1:0]        freq_khz;
    logic [4*BCD_DIGITS-1:0] freq_bcd;
    logic                    upd;
    logic                    busy;
    logic                    limit;

    modport master (
        output trig_up, trig_down, mode, load, load_khz, load_ftw,
        input  freq_ftw, freq_khz, freq_bcd, upd, busy, limit
    );

    modport slave (
        input  trig_up, trig_down, mode, load, load_khz, load_ftw,
        output freq_ftw, freq_khz, freq_bcd, upd, busy, limit
    );
endinterface

// File: rtl/freq_stepper.sv
// Manual DDS frequency controller: decade up/down steps with limits, preset loads, shift/add-3 BCD.
// Define FREQ_STEPPER_AUTOREPEAT_EN to make a held trigger auto-repeat (HOLDOFF, then every REPEAT).
module freq_stepper #(
    parameter int unsigned      FTW_W      = 32,
    parameter int unsigned      BIN_W      = 18,
    parameter int unsigned      BCD_DIGITS = 6,
    parameter logic [FTW_W-1:0] STEP_FTW0  = FTW_W'(32'h00A3D70A),
    parameter logic [FTW_W-1:0] STEP_FTW1  = FTW_W'(32'h0010624E),
    parameter logic [FTW_W-1:0] STEP_FTW2  = FTW_W'(32'h0001A36E),
    parameter logic [FTW_W-1:0] STEP_FTW3  = FTW_W'(32'h000029F1),
    parameter int unsigned      STEP_KHZ0  = 1000,
    parameter int unsigned      STEP_KHZ1  = 100,
    parameter int unsigned      STEP_KHZ2  = 10,
    parameter int unsigned      STEP_KHZ3  = 1,
    parameter int unsigned      MIN_KHZ    = 0,
    parameter int unsigned      MAX_KHZ    = 200000,
    parameter int unsigned      RESET_KHZ  = 100000,
    parameter logic [FTW_W-1:0] RESET_FTW  = FTW_W'(32'h3FFFFFE8),
    parameter int unsigned      WAIT_W     = 24,
    parameter int unsigned      HOLDOFF    = 1 << 23,
    parameter int unsigned      REPEAT     = 1 << 21
) (
    input logic           clk,
    input logic           rst,
    freq_stepper_if.slave bus
);
    localparam int unsigned BCD_W  = 4 * BCD_DIGITS;
    localparam int unsigned SH_W   = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam int unsigned CAND_W = BIN_W + 1;

    localparam logic [CAND_W-1:0] MIN_C     = CAND_W'(MIN_KHZ);
    localparam logic [CAND_W-1:0] SPAN_C    = CAND_W'(MAX_KHZ - MIN_KHZ);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(BIN_W - 1);
    localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(HOLDOFF - 1);
    localparam logic [WAIT_W-1:0] REP_LAST  = WAIT_W'(REPEAT - 1);

    typedef enum logic [2:0] {IDLE, CONV_INIT, CONV_ADD, CONV_SHIFT, DONE, HOLD} state_t;

    state_t             state, state_n;
    logic               up_q, down_q, load_q;
    logic [1:0]         mode_q;
    logic [FTW_W-1:0]   ftw_q, ftw_n;
    logic [BIN_W-1:0]   khz_q, khz_n;
    logic [BCD_W-1:0]   bcd_q, bcd_n;
    logic               upd_q, upd_n, limit_q, limit_n, busy_q, busy_n;
    logic [SH_W-1:0]    sh_q, sh_n;
    logic [CNT_W-1:0]   bit_q, bit_n;
    logic [WAIT_W-1:0]  hold_q, hold_n, hold_last;
    logic               from_step_q, from_step_n, rep_q, rep_n;
    logic [CAND_W-1:0]  step_khz, cand;
    logic [FTW_W-1:0]   step_ftw;
    logic               in_range;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Step size selection and candidate range check; an underflow wraps far above the span.
    always_comb begin
        step_khz = CAND_W'(STEP_KHZ0);
        step_ftw = STEP_FTW0;
        case (mode_q)
            2'd1: begin step_khz = CAND_W'(STEP_KHZ1); step_ftw = STEP_FTW1; end
            2'd2: begin step_khz = CAND_W'(STEP_KHZ2); step_ftw = STEP_FTW2; end
            2'd3: begin step_khz = CAND_W'(STEP_KHZ3); step_ftw = STEP_FTW3; end
            default: ;
        endcase
        cand      = up_q ? ({1'b0, khz_q} + step_khz) : ({1'b0, khz_q} - step_khz);
        in_range  = (cand - MIN_C) <= SPAN_C;
        hold_last = rep_q ? REP_LAST : HOLD_LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CONV_INIT;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            load_q      <= 1'b0;
            mode_q      <= 2'd0;
            ftw_q       <= RESET_FTW;
            khz_q       <= BIN_W'(RESET_KHZ);
            bcd_q       <= '0;
            upd_q       <= 1'b0;
            limit_q     <= 1'b0;
            busy_q      <= 1'b1;
            sh_q        <= '0;
            bit_q       <= '0;
            hold_q      <= '0;
            from_step_q <= 1'b0;
            rep_q       <= 1'b0;
        end else begin
            state       <= state_n;
            up_q        <= bus.trig_up;
            down_q      <= bus.trig_down;
            load_q      <= bus.load;
            mode_q      <= bus.mode;
            ftw_q       <= ftw_n;
            khz_q       <= khz_n;
            bcd_q       <= bcd_n;
            upd_q       <= upd_n;
            limit_q     <= limit_n;
            busy_q      <= busy_n;
            sh_q        <= sh_n;
            bit_q       <= bit_n;
            hold_q      <= hold_n;
            from_step_q <= from_step_n;
            rep_q       <= rep_n;
        end
    end

    always_comb begin
        state_n     = state;
        ftw_n       = ftw_q;
        khz_n       = khz_q;
        bcd_n       = bcd_q;
        upd_n       = 1'b0;
        limit_n     = 1'b0;
        sh_n        = sh_q;
        bit_n       = bit_q;
        hold_n      = '0;
        from_step_n = from_step_q;
        rep_n       = rep_q;

        case (state)
            IDLE: begin
                if (!up_q && !down_q) rep_n = 1'b0;
                if (load_q) begin
                    khz_n       = bus.load_khz;
                    ftw_n       = bus.load_ftw;
                    from_step_n = 1'b0;
                    state_n     = CONV_INIT;
                end else if (up_q ^ down_q) begin
                    if (in_range) begin
                        khz_n       = cand[BIN_W-1:0];
                        ftw_n       = up_q ? (ftw_q + step_ftw) : (ftw_q - step_ftw);
                        from_step_n = 1'b1;
                        state_n     = CONV_INIT;
                    end else begin
                        limit_n = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            CONV_INIT: begin
                sh_n    = SH_W'(khz_q);
                bit_n   = '0;
                state_n = CONV_ADD;
            end
            CONV_ADD: begin
                for (int i = 0; i < int'(BCD_DIGITS); i++)
                    sh_n[BIN_W + 4*i +: 4] = add3(sh_q[BIN_W + 4*i +: 4]);
                state_n = CONV_SHIFT;
            end
            CONV_SHIFT: begin
                sh_n    = sh_q << 1;
                bit_n   = bit_q + CNT_W'(1);
                state_n = (bit_q == LAST_BIT) ? DONE : CONV_ADD;
            end
            DONE: begin
                bcd_n   = sh_q[SH_W-1 -: BCD_W];
                upd_n   = 1'b1;
                state_n = from_step_q ? HOLD : IDLE;
            end
            HOLD: begin
                if (hold_q != hold_last) begin
                    hold_n = hold_q + WAIT_W'(1);
                end else begin
`ifdef FREQ_STEPPER_AUTOREPEAT_EN
                    rep_n   = 1'b1;
                    state_n = IDLE;
`else
                    hold_n = hold_q;
                    if (!up_q && !down_q) state_n = IDLE;
`endif
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.freq_ftw = ftw_q;
    assign bus.freq_khz = khz_q;
    assign bus.freq_bcd = bcd_q;
    assign bus.upd      = upd_q;
    assign bus.limit    = limit_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_freq_stepper.sv
// Scoreboard bench for freq_stepper: directed stimulus pushes expected upd/limit events,
// a negedge monitor pops and checks them (cycle, kind, kHz, FTW, BCD).
module tb_freq_stepper;
    localparam int unsigned FTW_W      = 32;
    localparam int unsigned BIN_W      = 18;
    localparam int unsigned BCD_DIGITS = 6;

    typedef struct {
        bit          lim;
        int unsigned cyc;
        logic [17:0] khz;
        logic [31:0] ftw;
        logic [23:0] bcd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    freq_stepper_if #(.FTW_W(FTW_W), .BIN_W(BIN_W), .BCD_DIGITS(BCD_DIGITS)) bus ();

    freq_stepper #(
        .FTW_W(FTW_W), .BIN_W(BIN_W), .BCD_DIGITS(BCD_DIGITS),
        .HOLDOFF(100), .REPEAT(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit lim, input int unsigned at, input logic [17:0] khz,
                        input logic [31:0] ftw, input logic [23:0] bcd);
        exp_t e;
        e.lim = lim; e.cyc = at; e.khz = khz; e.ftw = ftw; e.bcd = bcd;
        q.push_back(e);
    endtask

    // Monitor: every upd or limit strobe must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && (bus.upd === 1'b1 || bus.limit === 1'b1)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: upd=%b limit=%b khz=%0d at cycle %0d",
                         bus.upd, bus.limit, bus.freq_khz, cyc);
            end else begin
                e = q.pop_front();
                chk("event_kind_limit", 64'(bus.limit), 64'(e.lim));
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
                chk("freq_khz", 64'(bus.freq_khz), 64'(e.khz));
                chk("freq_ftw", 64'(bus.freq_ftw), 64'(e.ftw));
                chk("freq_bcd", 64'(bus.freq_bcd), 64'(e.bcd));
            end
        end
    end

    task automatic wait_idle(input int unsigned budget);
        int unsigned n = 0;
        repeat (3) @(negedge clk);
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("busy_returns_low", 64'(bus.busy), 64'(0));
    endtask

    // Single-cycle trigger pulse; ok=0 means a limit strobe is expected instead of upd.
    task automatic step(input bit up, input bit dn, input logic [1:0] m, input bit ok,
                        input logic [17:0] khz, input logic [31:0] ftw, input logic [23:0] bcd);
        push(!ok, cyc + (ok ? 40 : 2), khz, ftw, bcd);
        bus.trig_up = up; bus.trig_down = dn; bus.mode = m;
        @(negedge clk);
        bus.trig_up = 1'b0; bus.trig_down = 1'b0;
        wait_idle(400);
    endtask

    task automatic do_load(input logic [17:0] khz, input logic [31:0] ftw, input logic [23:0] bcd);
        push(1'b0, cyc + 40, khz, ftw, bcd);
        bus.load = 1'b1; bus.load_khz = khz; bus.load_ftw = ftw;
        @(negedge clk);
        bus.load = 1'b0;
        wait_idle(400);
    endtask

    initial begin
        bit bad;
        int unsigned c;
        bus.trig_up = 1'b0; bus.trig_down = 1'b0; bus.mode = 2'd0;
        bus.load = 1'b0; bus.load_khz = '0; bus.load_ftw = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ftw", 64'(bus.freq_ftw), 64'(32'h3FFFFFE8));
        chk("rst_khz", 64'(bus.freq_khz), 64'(100000));
        chk("rst_bcd", 64'(bus.freq_bcd), 64'(0));
        chk("rst_upd", 64'(bus.upd), 64'(0));
        chk("rst_limit", 64'(bus.limit), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(1));
        push(1'b0, cyc + 38, 18'd100000, 32'h3FFFFFE8, 24'h100000);
        rst = 1'b0;
        wait_idle(200);

        step(1'b1, 1'b0, 2'd0, 1'b1, 18'd101000, 32'h40A3D6F2, 24'h101000);
        step(1'b0, 1'b1, 2'd3, 1'b1, 18'd100999, 32'h40A3AD01, 24'h100999);
        do_load(18'd200000, 32'h7FFFFFD0, 24'h200000);
        step(1'b1, 1'b0, 2'd3, 1'b0, 18'd200000, 32'h7FFFFFD0, 24'h200000);
        do_load(18'd0, 32'h00000000, 24'h000000);
        step(1'b0, 1'b1, 2'd3, 1'b0, 18'd0, 32'h00000000, 24'h000000);
        step(1'b1, 1'b0, 2'd1, 1'b1, 18'd100, 32'h0010624E, 24'h000100);
        do_load(18'd199000, 32'h12345678, 24'h199000);
        step(1'b1, 1'b0, 2'd0, 1'b1, 18'd200000, 32'h12D82D82, 24'h200000);

        // Both triggers together must be ignored entirely.
        bad = 1'b0;
        bus.trig_up = 1'b1; bus.trig_down = 1'b1; bus.mode = 2'd0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) bad = 1'b1;
        end
        bus.trig_up = 1'b0; bus.trig_down = 1'b0;
        chk("both_trig_busy_seen", 64'(bad), 64'(0));
        repeat (5) @(negedge clk);
        chk("both_trig_khz", 64'(bus.freq_khz), 64'(200000));
        chk("both_trig_ftw", 64'(bus.freq_ftw), 64'(32'h12D82D82));

        // Held trigger for 200 cycles.
        do_load(18'd100000, 32'h3FFFFFE8, 24'h100000);
        c = cyc;
        push(1'b0, c + 40, 18'd100001, 32'h400029D9, 24'h100001);
`ifdef FREQ_STEPPER_AUTOREPEAT_EN
        push(1'b0, c + 179, 18'd100002, 32'h400053CA, 24'h100002);
        push(1'b0, c + 238, 18'd100003, 32'h40007DBB, 24'h100003);
`endif
        bus.trig_up = 1'b1; bus.mode = 2'd3;
        repeat (200) @(negedge clk);
        bus.trig_up = 1'b0;
        wait_idle(1000);
`ifdef FREQ_STEPPER_AUTOREPEAT_EN
        chk("held_final_khz", 64'(bus.freq_khz), 64'(100003));
`else
        chk("held_final_khz", 64'(bus.freq_khz), 64'(100001));
`endif

        // Reset while the conversion sits in CONV_SHIFT.
        bus.trig_up = 1'b1; bus.mode = 2'd2;
        @(negedge clk);
        bus.trig_up = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midconv_rst_bcd", 64'(bus.freq_bcd), 64'(0));
        chk("midconv_rst_khz", 64'(bus.freq_khz), 64'(100000));
        push(1'b0, cyc + 38, 18'd100000, 32'h3FFFFFE8, 24'h100000);
        rst = 1'b0;
        wait_idle(200);

        repeat (10) @(negedge clk);
        chk("events_outstanding", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
